axis_rr_arbiter: RTL

- Shares one axis_if stream sink between N axis_if stream sources, using packet-aware round-robin arbitration.
- Once a source's first beat is accepted, the grant stays locked to that source until the beat with last=1 is accepted.
- The output is a single registered stage, so it satisfies the team's master-port properties:
  - valid is held until ready;
  - data is stable while stalled.
- It sits in front of shared mesh egress links and shared DMA sinks.

---
 rtl/axis_arb_pkg.sv | 38 +++
 rtl/axis_rr_pick.sv | 25 ++
 rtl/axis_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared helpers for the packet-aware stream arbiter: source-index width and the
// rotating first-requester search used to pick the next grant.
package axis_arb_pkg;

  localparam int unsigned MAX_N = 32;
  localparam int unsigned MAX_W = 5;

  typedef struct packed {
    logic             found;
    logic [MAX_W-1:0] idx;
  } pick_t;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Only the low n bits of req are live; ptr < n keeps every candidate below 2n,
  // so one conditional subtraction performs the modulo.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [MAX_W-1:0] ptr,
                                    input int unsigned      n);
    pick_t       res;
    logic [31:0] idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!res.found && req[idx[MAX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[MAX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin requester search: first asserted req at or after ptr, wrapping modulo N.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SRC_W = src_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] gnt,
  output logic             gnt_vld
);

  logic [MAX_N-1:0] req_ext;
  pick_t            pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, MAX_W'(ptr), N);
    gnt            = SRC_W'(pick.idx);
    gnt_vld        = pick.found;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 stream arbiter: round-robin between packets, grant locked until last,
// single registered output stage giving one beat per cycle.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned N      = 4,
  parameter  type         data_t = logic [31:0],
  localparam int unsigned SRC_W  = src_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  data_t            in_data [N],
  input  logic [N-1:0]     in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output logic             out_last,
  output logic [SRC_W-1:0] out_src
);

  logic             out_valid_q, out_valid_d;
  data_t            out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             locked_q, locked_d;
  logic [SRC_W-1:0] lock_src_q, lock_src_d;

  logic [SRC_W-1:0] pick_gnt;
  logic             pick_vld;
  logic [SRC_W-1:0] gnt;
  logic             gnt_vld;
  logic             load;
  logic             acc;

  axis_rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_vld (pick_vld)
  );

  // While a packet is open only its owner can be granted, even if it idles.
  always_comb begin
    load    = ~out_valid_q | out_ready;
    gnt     = pick_gnt;
    gnt_vld = pick_vld;
    if (locked_q) begin
      gnt     = lock_src_q;
      gnt_vld = in_valid[lock_src_q];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = rst & load & gnt_vld & (gnt == SRC_W'(gi));
  end

  assign acc = in_valid[gnt] & in_ready[gnt];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    locked_d    = locked_q;
    lock_src_d  = lock_src_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt];
      out_last_d  = in_last[gnt];
      out_src_d   = gnt;
      if (in_last[gnt]) begin
        locked_d = 1'b0;
        rr_ptr_d = (gnt == SRC_W'(N - 1)) ? '0 : gnt + SRC_W'(1);
      end else begin
        locked_d   = 1'b1;
        lock_src_d = gnt;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
      locked_q    <= 1'b0;
      lock_src_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_q    <= locked_d;
      lock_src_q  <= lock_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
